// File: rtl/hamming_link_pkg.sv
// Shared Hamming(7,4) definitions for the secure link.
// Holds the codeword type, the link geometry constants and the pure encode and
// syndrome functions used by the top level and by the decoder.
//
// Codeword layout (bit index = Hamming position - 1):
//   [0]=p1 [1]=p2 [2]=d0 [3]=p4 [4]=d1 [5]=d2 [6]=d3
package hamming_link_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned CW_W   = 7;
  localparam int unsigned NUM_CH = 4;
  localparam logic [2:0]  NO_INJ = 3'd7;

  typedef logic [CW_W-1:0] codeword_t;

  function automatic codeword_t ham74_encode(input logic [DATA_W-1:0] d);
    codeword_t cw;
    cw[0] = d[0] ^ d[1] ^ d[3];
    cw[1] = d[0] ^ d[2] ^ d[3];
    cw[2] = d[0];
    cw[3] = d[1] ^ d[2] ^ d[3];
    cw[4] = d[1];
    cw[5] = d[2];
    cw[6] = d[3];
    return cw;
  endfunction

  // A non-zero syndrome is the 1-based position of the single flipped bit.
  function automatic logic [2:0] ham74_syndrome(input codeword_t cw);
    logic s1, s2, s4;
    s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    s4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    return {s4, s2, s1};
  endfunction

endpackage

// File: rtl/hamming74_decoder.sv
// Combinational Hamming(7,4) single-error-correcting decoder.
// Ports:
//   cw_i   - received 7-bit codeword
//   data_o - corrected 4-bit data {cw6,cw5,cw4,cw2}
//   err_o  - syndrome non-zero (only with SECURE_LINK_ERR_FLAG_EN defined)
module hamming74_decoder
  import hamming_link_pkg::*;
(
  input  codeword_t         cw_i,
`ifdef SECURE_LINK_ERR_FLAG_EN
  output logic              err_o,
`endif
  output logic [DATA_W-1:0] data_o
);

  logic [2:0] syn;
  logic [2:0] flip_pos;
  codeword_t  fixed;

  always_comb begin
    syn      = ham74_syndrome(cw_i);
    flip_pos = syn - 3'd1;
    fixed    = cw_i;
    if (syn != 3'd0) begin
      fixed[flip_pos] = ~cw_i[flip_pos];
    end
    data_o = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end

`ifdef SECURE_LINK_ERR_FLAG_EN
  assign err_o = (syn != 3'd0);
`endif

endmodule

// File: rtl/hamming_secure_link.sv
// Four-channel secure router protected by Hamming(7,4) coding.
// d_in[3:0] is encoded and routed to channel d_in[5:4]; the other channels carry
// the all-zero codeword. Each channel may have one bit inverted (fault
// injection) before the stage-1 register, then is decoded with single-error
// correction.
// Parameter:
//   PIPE_OUT - 1: registered outputs (latency 2), 0: outputs from decoder (latency 1)
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   d_in[5:0]          - [5:4] channel select, [3:0] data nibble
//   err_pos0..3[2:0]   - bit index to invert per channel, 7 = no injection
//   d_disp0..3[3:0]    - corrected data per channel
//   err_flag[3:0]      - per-channel non-zero syndrome
//                        (only with SECURE_LINK_ERR_FLAG_EN defined)
module hamming_secure_link
  import hamming_link_pkg::*;
#(
  parameter int unsigned PIPE_OUT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] d_in,
  input  logic [2:0] err_pos0,
  input  logic [2:0] err_pos1,
  input  logic [2:0] err_pos2,
  input  logic [2:0] err_pos3,
`ifdef SECURE_LINK_ERR_FLAG_EN
  output logic [3:0] err_flag,
`endif
  output logic [3:0] d_disp0,
  output logic [3:0] d_disp1,
  output logic [3:0] d_disp2,
  output logic [3:0] d_disp3
);

  logic [1:0]  sel;
  codeword_t   enc_cw;
  logic [2:0]  err_pos [NUM_CH];
  codeword_t   tx_cw   [NUM_CH];
  codeword_t   cw_q    [NUM_CH];

  logic [NUM_CH-1:0][DATA_W-1:0] disp_d;
  logic [NUM_CH-1:0][DATA_W-1:0] disp_out;

  assign sel        = d_in[5:4];
  assign enc_cw     = ham74_encode(d_in[3:0]);
  assign err_pos[0] = err_pos0;
  assign err_pos[1] = err_pos1;
  assign err_pos[2] = err_pos2;
  assign err_pos[3] = err_pos3;

  // Routing and fault injection; unselected channels still get injected.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      tx_cw[ch] = (sel == 2'(ch)) ? enc_cw : '0;
      if (err_pos[ch] != NO_INJ) begin
        tx_cw[ch][err_pos[ch]] = ~tx_cw[ch][err_pos[ch]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cw_q[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cw_q[ch] <= tx_cw[ch];
      end
    end
  end

`ifdef SECURE_LINK_ERR_FLAG_EN
  logic [NUM_CH-1:0] flag_d;
  logic [NUM_CH-1:0] flag_out;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
    hamming74_decoder u_dec (
      .cw_i   (cw_q[g]),
`ifdef SECURE_LINK_ERR_FLAG_EN
      .err_o  (flag_d[g]),
`endif
      .data_o (disp_d[g])
    );
  end

  if (PIPE_OUT != 0) begin : g_pipe
    logic [NUM_CH-1:0][DATA_W-1:0] disp_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        disp_q <= '0;
      end else begin
        disp_q <= disp_d;
      end
    end
    assign disp_out = disp_q;
`ifdef SECURE_LINK_ERR_FLAG_EN
    logic [NUM_CH-1:0] flag_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        flag_q <= '0;
      end else begin
        flag_q <= flag_d;
      end
    end
    assign flag_out = flag_q;
`endif
  end else begin : g_comb
    assign disp_out = disp_d;
`ifdef SECURE_LINK_ERR_FLAG_EN
    assign flag_out = flag_d;
`endif
  end

  assign d_disp0 = disp_out[0];
  assign d_disp1 = disp_out[1];
  assign d_disp2 = disp_out[2];
  assign d_disp3 = disp_out[3];

`ifdef SECURE_LINK_ERR_FLAG_EN
  assign err_flag = flag_out;
`endif

endmodule

// File: tb/tb_hamming_secure_link.sv
// Scoreboard bench for hamming_secure_link: the driver pushes the expected
// outputs for each word, the monitor pops and compares when the word's latency
// has elapsed. Works with or without SECURE_LINK_ERR_FLAG_EN.
module tb_hamming_secure_link;

  localparam int unsigned PIPE_OUT = 1;
  localparam int unsigned LAT      = (PIPE_OUT != 0) ? 2 : 1;

  typedef struct packed {
    logic [15:0] disp;
    logic [3:0]  flag;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] d_in;
  logic [2:0] err_pos0, err_pos1, err_pos2, err_pos3;
  logic [3:0] d_disp0, d_disp1, d_disp2, d_disp3;
`ifdef SECURE_LINK_ERR_FLAG_EN
  logic [3:0] err_flag;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  logic in_vld;
  logic [1:0] vld_pipe;

  hamming_secure_link #(
    .PIPE_OUT (PIPE_OUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_in     (d_in),
    .err_pos0 (err_pos0),
    .err_pos1 (err_pos1),
    .err_pos2 (err_pos2),
    .err_pos3 (err_pos3),
`ifdef SECURE_LINK_ERR_FLAG_EN
    .err_flag (err_flag),
`endif
    .d_disp0  (d_disp0),
    .d_disp1  (d_disp1),
    .d_disp2  (d_disp2),
    .d_disp3  (d_disp3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tracks which cycles carry a scoreboarded word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[0], in_vld};
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] disp_all();
    return {d_disp3, d_disp2, d_disp1, d_disp0};
  endfunction

  task automatic check_zero(input string name);
    check(name, disp_all(), 16'h0000);
`ifdef SECURE_LINK_ERR_FLAG_EN
    check({name, "_flag"}, {12'h0, err_flag}, 16'h0000);
`endif
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n && vld_pipe[LAT-1]) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got output with empty queue at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("disp", disp_all(), e.disp);
`ifdef SECURE_LINK_ERR_FLAG_EN
        check("err_flag", {12'h0, err_flag}, {12'h0, e.flag});
`endif
      end
    end
  end

  task automatic issue(input logic [5:0] d, input logic [2:0] e0, input logic [2:0] e1,
                       input logic [2:0] e2, input logic [2:0] e3,
                       input logic [15:0] exp_disp, input logic [3:0] exp_flag);
    exp_t e;
    d_in     = d;
    err_pos0 = e0;
    err_pos1 = e1;
    err_pos2 = e2;
    err_pos3 = e3;
    in_vld   = 1'b1;
    e.disp   = exp_disp;
    e.flag   = exp_flag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_vld   = 1'b0;
    d_in     = 6'h00;
    err_pos0 = 3'd7;
    err_pos1 = 3'd7;
    err_pos2 = 3'd7;
    err_pos3 = 3'd7;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  ep [4];
    logic [15:0] xd;
    logic [3:0]  xf;

    rst_n    = 1'b0;
    in_vld   = 1'b0;
    d_in     = 6'h2B;
    err_pos0 = 3'd0;
    err_pos1 = 3'd2;
    err_pos2 = 3'd4;
    err_pos3 = 3'd6;

    // Reset with no clock edge yet, then with edges while held.
    #3;
    check_zero("reset_noclk");
    #10;
    check_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Route and correct: one flip per channel, flags all set.
    issue(6'b10_1011, 3'd0, 3'd2, 3'd4, 3'd6, 16'h0B00, 4'hF);
    // No injection.
    issue(6'b01_0110, 3'd7, 3'd7, 3'd7, 3'd7, 16'h0060, 4'h0);
    // Streaming.
    issue(6'h05, 3'd7, 3'd7, 3'd7, 3'd7, 16'h0005, 4'h0);
    issue(6'h1A, 3'd7, 3'd7, 3'd7, 3'd7, 16'h00A0, 4'h0);
    issue(6'h3F, 3'd7, 3'd7, 3'd7, 3'd7, 16'hF000, 4'h0);
    idle(LAT + 1);

    // Sweep: every select, data value and error position; the unselected
    // channels get a rotating error position too.
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < 16; d++) begin
        for (int e = 0; e < 8; e++) begin
          xf = '0;
          for (int ch = 0; ch < 4; ch++) begin
            ep[ch] = (ch == s) ? 3'(e) : 3'((e + ch + 1) % 8);
            xf[ch] = (ep[ch] != 3'd7);
          end
          xd = '0;
          xd[4*s +: 4] = 4'(d);
          issue({2'(s), 4'(d)}, ep[0], ep[1], ep[2], ep[3], xd, xf);
        end
      end
    end
    idle(LAT + 1);

    // Reset mid-stream.
    issue(6'h3F, 3'd7, 3'd7, 3'd7, 3'd7, 16'hF000, 4'h0);
    in_vld = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_disp", disp_all(), 16'hF000);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    sb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("rst_midstream_held");
    @(negedge clk);
    rst_n = 1'b1;
    issue(6'h1A, 3'd7, 3'd3, 3'd7, 3'd7, 16'h00A0, 4'h2);
    issue(6'h2C, 3'd7, 3'd7, 3'd7, 3'd7, 16'h0C00, 4'h0);
    idle(LAT + 1);

    check("sb_drained", 16'(sb_q.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
